// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and constants for the round-robin 3-to-8 decoder arbiter.
package rr_decoder_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Decoder behaviour: one-hot of a select code.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_pick8.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick8
  import rr_decoder_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    // Offset 8 wraps back to 'last' itself, so the previous owner comes last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 decoder with a dead cycle on hand-over.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic             sel_en_n,
  output logic [N_REQ-1:0] gnt,
  output logic             busy
);

  localparam int                 HOLD_W   = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t             state, state_next;
  logic [SEL_W-1:0]   last, last_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic [SEL_W-1:0]   sel_next;
  logic               sel_en_n_next, busy_next;
  logic [N_REQ-1:0]   gnt_next;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_win;
  logic               contended, release_now;

  rr_pick8 u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  // Owner dropping and forced rotation collapse into one release condition.
  always_comb begin
    contended   = |(req & ~onehot(sel));
    release_now = (state == GRANT) &&
                  (!req[sel] || (hold_cnt == HOLD_MAX && contended));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 3'd7;
      hold_cnt <= '0;
      sel      <= '0;
      sel_en_n <= 1'b1;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      hold_cnt <= hold_next;
      sel      <= sel_next;
      sel_en_n <= sel_en_n_next;
      gnt      <= gnt_next;
      busy     <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANT;
      GRANT:   if (release_now) state_next = GAP;
      GAP:     state_next = pick_any ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last_next     = last;
    hold_next     = hold_cnt;
    sel_next      = sel;
    sel_en_n_next = sel_en_n;
    gnt_next      = gnt;
    if (state != GRANT && pick_any) begin
      sel_next      = pick_win;
      sel_en_n_next = 1'b0;
      gnt_next      = onehot(pick_win);
      hold_next     = HOLD_W'(1);
    end else if (release_now) begin
      // sel keeps the old owner; it is ignored while the decoder is disabled.
      sel_en_n_next = 1'b1;
      gnt_next      = '0;
      last_next     = sel;
      hold_next     = '0;
    end else if (state == GRANT && hold_cnt != HOLD_MAX) begin
      hold_next = hold_cnt + HOLD_W'(1);
    end
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rr_decoder_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [2:0] sel, sel1;
  logic       sel_en_n, sel_en_n1, busy, busy1;
  logic [7:0] gnt, gnt1;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = none), gap flag, pointer, consecutive-hold count.
  int m_owner, m_last, m_held, m_sel;
  bit m_gap;

  rr_decoder_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel), .sel_en_n(sel_en_n), .gnt(gnt), .busy(busy)
  );

  rr_decoder_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel1), .sel_en_n(sel_en_n1), .gnt(gnt1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_last = 7; m_held = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic others;
    if (m_owner >= 0) begin
      others = (r & ~(8'd1 << m_owner)) != 8'd0;
      if (!r[m_owner] || (m_held >= MH && others)) begin
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end else begin
        m_held++;
      end
    end else if (r != 8'd0) begin
      for (int k = 1; k <= 8; k++)
        if (m_owner < 0 && r[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
      m_held = 1; m_gap = 0; m_sel = m_owner;
    end else begin
      m_gap = 0;
    end
  endtask

  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
    model_step(r);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt !== 8'h00 || sel_en_n !== 1'b1 || sel !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_clocked: gnt=%h en_n=%b sel=%0d busy=%b want 00/1/0/0", gnt, sel_en_n, sel, busy);
    end
    rst_n = 1'b1;
    model_reset();
    cycle(8'h08);
    total++;
    if (gnt !== 8'h08) begin
      bad++;
      $display("FAIL reset_pre_grant: gnt=%h want 08", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 8'h00 || sel_en_n !== 1'b1 || sel !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: gnt=%h en_n=%b sel=%0d busy=%b want 00/1/0/0", gnt, sel_en_n, sel, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(8'h08);
      total++;
      if (gnt !== 8'h08 || sel !== 3'd3 || sel_en_n !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL single[%0d]: gnt=%h sel=%0d en_n=%b busy=%b want 08/3/0/1", i, gnt, sel, sel_en_n, busy);
      end
    end
    cycle(8'h00);
    total++;
    if (gnt !== 8'h00 || sel_en_n !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gap: gnt=%h en_n=%b busy=%b want 00/1/1", gnt, sel_en_n, busy);
    end
    cycle(8'h00);
    total++;
    if (busy !== 1'b0 || gnt !== 8'h00) begin
      bad++;
      $display("FAIL single_idle: busy=%b gnt=%h want 0/00", busy, gnt);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cycle(8'h81);
      exp = (k % 5 == 4) ? 8'h00 : (((k / 5) % 2 == 0) ? 8'h01 : 8'h80);
      total++;
      if (gnt !== exp) begin
        bad++;
        $display("FAIL contention[%0d]: gnt=%h want %h", k, gnt, exp);
      end
    end
  endtask

  task automatic test_early_release();
    logic [7:0] reqs [4] = '{8'h14, 8'h14, 8'h10, 8'h10};
    logic [7:0] exps [4] = '{8'h04, 8'h04, 8'h00, 8'h10};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(reqs[k]);
      total++;
      if (gnt !== exps[k]) begin
        bad++;
        $display("FAIL early_release[%0d]: gnt=%h want %h", k, gnt, exps[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] reqs [8] = '{8'h80, 8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    logic [7:0] exps [8] = '{8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h40};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(reqs[k]);
      total++;
      if (gnt !== exps[k]) begin
        bad++;
        $display("FAIL wrap[%0d]: gnt=%h want %h", k, gnt, exps[k]);
      end
    end
  endtask

  task automatic test_late_arrival();
    logic [7:0] reqs [6] = '{8'h20, 8'h20, 8'h22, 8'h22, 8'h22, 8'h22};
    logic [7:0] exps [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h02};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(reqs[k]);
      total++;
      if (gnt !== exps[k]) begin
        bad++;
        $display("FAIL late_arrival[%0d]: gnt=%h want %h", k, gnt, exps[k]);
      end
    end
  endtask

  task automatic test_max_hold_one();
    logic [7:0] exps [6] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(8'h81);
      total++;
      if (gnt1 !== exps[k]) begin
        bad++;
        $display("FAIL max_hold_one[%0d]: gnt=%h want %h", k, gnt1, exps[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] exp_gnt;
    do_reset();
    r = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      cycle(r);
      exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
      total++;
      if (gnt !== exp_gnt || sel_en_n !== (m_owner < 0) || busy !== (m_owner >= 0 || m_gap) ||
          sel !== 3'(m_sel)) begin
        bad++;
        $display("FAIL random[%0d]: req=%h gnt=%h sel=%0d en_n=%b busy=%b want %h/%0d/%b/%b",
                 k, r, gnt, sel, sel_en_n, busy, exp_gnt, m_sel, (m_owner < 0), (m_owner >= 0 || m_gap));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_wrap();
    test_late_arrival();
    test_max_hold_one();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
